// File: rtl/alu_sequencer.sv
// Initiator for a registered 16-bit ALU: accepts register-to-register commands, drives the ALU,
// captures its registered result and flags, writes back and returns a response.
module alu_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rs,
    input  logic [2:0]       cmd_rt,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_slt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapt, StResp} state_e;

    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpSlt = 3'd4;
    localparam logic [2:0] OpLi  = 3'd5;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [2:0]       rd_q, rd_d, op_q, op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] wb_val;

    // rf_q[0] is never written, so it always reads zero
    assign wb_val = (op_q == OpSlt) ? {{(WIDTH-1){1'b0}}, alu_slt} : alu_result;

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rd_d       = rd_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_op <= OpSlt) begin
                        alu_a_d    = rf_q[cmd_rs];
                        alu_b_d    = rf_q[cmd_rt];
                        alu_ctrl_d = cmd_op;
                        rd_d       = cmd_rd;
                        op_d       = cmd_op;
                        state_d    = StIssue;
                    end else if (cmd_op == OpLi) begin
                        if (cmd_rd != 3'd0) rf_d[cmd_rd] = cmd_imm;
                        rsp_data_d = cmd_imm;
                        rsp_zero_d = (cmd_imm == '0);
                        rsp_ovf_d  = 1'b0;
                        rsp_err_d  = 1'b0;
                        state_d    = StResp;
                    end else begin
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b1;
                        rsp_ovf_d  = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StIssue: state_d = StWait;
            // ALU Zero lags Result by one edge, so flags are sampled one cycle after Result
            StWait:  state_d = StCapt;
            StCapt: begin
                if (rd_q != 3'd0) rf_d[rd_q] = wb_val;
                rsp_data_d = wb_val;
                rsp_zero_d = (op_q == OpSlt) ? ~alu_slt : alu_zero;
                rsp_ovf_d  = (op_q <= OpSub) ? alu_overflow : 1'b0;
                rsp_err_d  = 1'b0;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctrl_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_data    = (dbg_addr == 3'd0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a registered ALU model in the environment, and a
// register-file reference model that predicts every response.
module tb_alu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        alu_zero, alu_overflow, alu_slt;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_ovf, rsp_err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m [8];
    logic [15:0] last_a, last_b;
    logic [2:0]  last_c;

    always #5 clock = ~clock;

    alu_sequencer #(.WIDTH(16), .NREG(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_slt(alu_slt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Registered ALU: Result/Overflow/SLT one edge after operands, Zero one edge after Result
    logic [15:0] a_add, a_sub;
    assign a_add = alu_a + alu_b;
    assign a_sub = alu_a - alu_b;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= '0; alu_overflow <= 1'b0; alu_slt <= 1'b0; alu_zero <= 1'b0;
        end else begin
            alu_zero     <= (alu_result == 16'd0);
            alu_slt      <= a_sub[15] ^ ((alu_a[15] ^ alu_b[15]) & (a_sub[15] ^ alu_a[15]));
            alu_overflow <= 1'b0;
            case (alu_control)
                3'd0: begin
                    alu_result   <= a_add;
                    alu_overflow <= ~(alu_a[15] ^ alu_b[15]) & (a_add[15] ^ alu_a[15]);
                end
                3'd1: begin
                    alu_result   <= a_sub;
                    alu_overflow <= (alu_a[15] ^ alu_b[15]) & (a_sub[15] ^ alu_a[15]);
                end
                3'd2: alu_result <= alu_a & alu_b;
                3'd3: alu_result <= alu_a | alu_b;
                3'd4: alu_result <= {15'd0, a_sub[15] ^
                                     ((alu_a[15] ^ alu_b[15]) & (a_sub[15] ^ alu_a[15]))};
                default: alu_result <= 16'd0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; issues one command and completes its response.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [15:0] imm, input int hold);
        logic [15:0] a, b, ev;
        logic        eovf, eerr;
        int          s, lat, elat;
        a = m[rs];
        b = m[rt];
        eovf = 1'b0;
        eerr = 1'b0;
        case (op)
            3'd0: begin s = int'($signed(a)) + int'($signed(b)); ev = 16'(s);
                        eovf = (s > 32767) || (s < -32768); end
            3'd1: begin s = int'($signed(a)) - int'($signed(b)); ev = 16'(s);
                        eovf = (s > 32767) || (s < -32768); end
            3'd2: ev = a & b;
            3'd3: ev = a | b;
            3'd4: ev = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'd5: ev = imm;
            default: begin ev = 16'd0; eerr = 1'b1; end
        endcase
        elat = (op <= 3'd4) ? 4 : 1;

        cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm; cmd_valid = 1'b1;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        if (op <= 3'd4) begin
            last_a = a; last_b = b; last_c = op;
        end
        check("alu_a", {16'd0, alu_a}, {16'd0, last_a});
        check("alu_b", {16'd0, alu_b}, {16'd0, last_b});
        check("alu_control", {29'd0, alu_control}, {29'd0, last_c});
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        check("latency", lat, elat);
        check("rsp_data", {16'd0, rsp_data}, {16'd0, ev});
        check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, eovf});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, eerr});
        if (!eerr) check("rsp_zero", {31'd0, rsp_zero}, {31'd0, ev == 16'd0});
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_data", {16'd0, rsp_data}, {16'd0, ev});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("rsp_done_ready", {31'd0, cmd_ready}, 32'd1);
        if (op <= 3'd5 && rd != 3'd0) m[rd] = ev;
        dbg_addr = rd;
        #1;
        check("dbg_rd", {16'd0, dbg_data}, {16'd0, m[rd]});
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check(tag, {16'd0, dbg_data}, {16'd0, m[i]});
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
        cmd_imm = '0; rsp_ready = 1'b0; dbg_addr = '0;
        for (int i = 0; i < 8; i++) m[i] = '0;
        last_a = '0; last_b = '0; last_c = '0;
        repeat (2) @(negedge clock);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_all_regs("rst_regs");
        @(negedge clock);

        // Directed sequence
        run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 16'h0005, 0);
        run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 16'h0003, 0);
        run_cmd(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 0);
        run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 16'h7FFF, 0);
        run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 16'h0001, 0);
        run_cmd(3'd0, 3'd4, 3'd1, 3'd2, 16'h0000, 0);
        run_cmd(3'd1, 3'd5, 3'd2, 3'd2, 16'h0000, 0);
        run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 16'h0002, 0);
        run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 16'h0009, 0);
        run_cmd(3'd4, 3'd3, 3'd1, 3'd2, 16'h0000, 0);
        run_cmd(3'd4, 3'd3, 3'd2, 3'd1, 16'h0000, 0);
        run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 16'hF0F0, 0);
        run_cmd(3'd5, 3'd2, 3'd0, 3'd0, 16'h0FF0, 0);
        run_cmd(3'd2, 3'd3, 3'd1, 3'd2, 16'h0000, 0);
        run_cmd(3'd3, 3'd4, 3'd1, 3'd2, 16'h0000, 0);
        run_cmd(3'd0, 3'd0, 3'd1, 3'd2, 16'h0000, 0);
        run_cmd(3'd6, 3'd5, 3'd1, 3'd2, 16'h1234, 5);
        run_cmd(3'd7, 3'd6, 3'd1, 3'd2, 16'h0000, 0);
        check_all_regs("regs_after_directed");

        // Reset during WAIT of an ADD
        run_cmd(3'd5, 3'd6, 3'd0, 3'd0, 16'h1234, 0);
        cmd_op = 3'd0; cmd_rd = 3'd6; cmd_rs = 3'd1; cmd_rt = 3'd2; cmd_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) m[i] = '0;
        last_a = '0; last_b = '0; last_c = '0;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_alu_a", {16'd0, alu_a}, 32'd0);
        check("abort_alu_b", {16'd0, alu_b}, 32'd0);
        check("abort_alu_ctrl", {29'd0, alu_control}, 32'd0);
        check_all_regs("abort_regs");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_cmd(3'd5, 3'd1, 3'd0, 3'd0, 16'h0011, 0);
        run_cmd(3'd0, 3'd6, 3'd1, 3'd1, 16'h0000, 1);

        // Randomized commands
        for (int n = 0; n < 300; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom),
                    int'($urandom_range(0, 3)));
        end
        check_all_regs("regs_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
